aidc_lite_comp_core: RTL and testbench

Compression core of AIDC-Lite. It sits directly downstream of the compression engine's block fetch and upstream of its write-back.
- It owns the 128 B block buffer that the engine fills from AHB read data.
- On a start pulse it converts the block's 32 FP32 words to 32 BF16 words, a fixed 2:1 lossy compression.
- It then streams the resulting 64 B block back to the engine as 16 × 32-bit words, one per read-enable, to feed the AHB write data phases.

---
 rtl/aidc_lite_pkg.sv | 16 +
 rtl/aidc_lite_comp_core_if.sv | 28 ++
 rtl/aidc_lite_fp32_to_bf16.sv | 31 +++
 rtl/aidc_lite_comp_core.sv | 111 +++++++++++
 tb/tb_aidc_lite_comp_core.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/aidc_lite_pkg.sv
// Shared types and constants for the AIDC-Lite compression core.
package aidc_lite_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_READY = 2'd2
  } state_e;

  localparam int          BLK_ENTRIES    = 16;
  localparam logic [6:0]  BF16_QNAN_FRAC = 7'h40;

  localparam int ROUND_RNE   = 0;
  localparam int ROUND_TRUNC = 1;

endpackage

// File: rtl/aidc_lite_comp_core_if.sv
// Engine <-> compression core bus: block buffer fill, start, compressed readout.
interface aidc_lite_comp_core_if;

  logic        buf_wren_i;
  logic [3:0]  buf_waddr_i;
  logic [7:0]  buf_wbe_i;
  logic [63:0] buf_wdata_i;
  logic        comp_start_i;
  logic        comp_ready_o;
  logic        comp_rden_i;
  logic [31:0] comp_rdata_o;
  logic        comp_ovf_o;

  // Engine side
  modport master (
    output buf_wren_i, buf_waddr_i, buf_wbe_i, buf_wdata_i,
    output comp_start_i, comp_rden_i,
    input  comp_ready_o, comp_rdata_o, comp_ovf_o
  );

  // Core side
  modport slave (
    input  buf_wren_i, buf_waddr_i, buf_wbe_i, buf_wdata_i,
    input  comp_start_i, comp_rden_i,
    output comp_ready_o, comp_rdata_o, comp_ovf_o
  );

endinterface

// File: rtl/aidc_lite_fp32_to_bf16.sv
// Combinational FP32 -> BF16 converter with NaN quieting and overflow flag.
module aidc_lite_fp32_to_bf16
  import aidc_lite_pkg::*;
#(
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic [31:0] f_i,
  output logic [15:0] bf16_o,
  output logic        ovf_o
);

  logic        is_nan;
  logic        rnd;
  logic [15:0] sum;

  // Round upper half; a finite input whose result exponent saturates became Inf
  always_comb begin
    is_nan = (f_i[30:23] == 8'hFF) && (f_i[22:0] != 23'd0);
    rnd    = f_i[15] & ((|f_i[14:0]) | f_i[16]);
    sum    = f_i[31:16] + {15'd0, rnd};
    bf16_o = f_i[31:16];
    ovf_o  = 1'b0;
    if (is_nan) begin
      bf16_o = {f_i[31], 8'hFF, BF16_QNAN_FRAC};
    end else if (ROUND_MODE == ROUND_RNE) begin
      bf16_o = sum;
      ovf_o  = (f_i[30:23] != 8'hFF) && (sum[14:7] == 8'hFF);
    end
  end

endmodule

// File: rtl/aidc_lite_comp_core.sv
// AIDC-Lite compression core: 128 B FP32 block buffer, serial BF16 conversion,
// and 16-word compressed readout.
module aidc_lite_comp_core
  import aidc_lite_pkg::*;
#(
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic                  clk,
  input  logic                  rst,
  aidc_lite_comp_core_if.slave  bus
);

  logic [BLK_ENTRIES-1:0][63:0] buf_q;
  logic [BLK_ENTRIES-1:0][31:0] out_word_q;

  state_e     state_q, state_d;
  logic [3:0] conv_cnt_q, conv_cnt_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic       ovf_q, ovf_d;

  logic [63:0] cur_entry;
  logic [15:0] bf_hi, bf_lo;
  logic        ovf_hi, ovf_lo;

  assign cur_entry = buf_q[conv_cnt_q];

  // Entry bits [63:32] hold the even FP32 word, [31:0] the odd one
  aidc_lite_fp32_to_bf16 #(.ROUND_MODE(ROUND_MODE)) u_cvt_hi (
    .f_i    (cur_entry[63:32]),
    .bf16_o (bf_hi),
    .ovf_o  (ovf_hi)
  );

  aidc_lite_fp32_to_bf16 #(.ROUND_MODE(ROUND_MODE)) u_cvt_lo (
    .f_i    (cur_entry[31:0]),
    .bf16_o (bf_lo),
    .ovf_o  (ovf_lo)
  );

  // Block buffer: byte-enabled writes accepted in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (bus.buf_wren_i) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.buf_wbe_i[b]) buf_q[bus.buf_waddr_i][8*b +: 8] <= bus.buf_wdata_i[8*b +: 8];
      end
    end
  end

  // Compressed word store: odd word in the upper half, even word in the lower
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word_q <= '0;
    end else if (state_q == S_CONV) begin
      out_word_q[conv_cnt_q] <= {bf_lo, bf_hi};
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state: start only honoured in idle, pops only honoured when ready
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.comp_start_i) begin
          conv_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        ovf_d      = ovf_q | ovf_hi | ovf_lo;
        conv_cnt_d = conv_cnt_q + 4'd1;
        if (conv_cnt_q == 4'd15) begin
          rd_ptr_d = '0;
          state_d  = S_READY;
        end
      end
      S_READY: begin
        if (bus.comp_rden_i) begin
          rd_ptr_d = rd_ptr_q + 4'd1;
          if (rd_ptr_q == 4'd15) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.comp_ready_o = (state_q == S_READY);
  assign bus.comp_rdata_o = (state_q == S_READY) ? out_word_q[rd_ptr_q] : 32'd0;
  assign bus.comp_ovf_o   = ovf_q;

endmodule

// File: tb/tb_aidc_lite_comp_core.sv
// Directed bench for aidc_lite_comp_core: an RNE instance and a truncate
// instance see identical stimulus.
module tb_aidc_lite_comp_core;
  import aidc_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] wa [16];
  logic [31:0] wb [16];

  aidc_lite_comp_core_if ifa ();
  aidc_lite_comp_core_if ifb ();

  assign ifb.buf_wren_i   = ifa.buf_wren_i;
  assign ifb.buf_waddr_i  = ifa.buf_waddr_i;
  assign ifb.buf_wbe_i    = ifa.buf_wbe_i;
  assign ifb.buf_wdata_i  = ifa.buf_wdata_i;
  assign ifb.comp_start_i = ifa.comp_start_i;
  assign ifb.comp_rden_i  = ifa.comp_rden_i;

  aidc_lite_comp_core #(.ROUND_MODE(ROUND_RNE)) dut_rne (
    .clk (clk), .rst (rst), .bus (ifa)
  );

  aidc_lite_comp_core #(.ROUND_MODE(ROUND_TRUNC)) dut_trunc (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] be, input logic [63:0] d);
    ifa.buf_wren_i  = 1'b1;
    ifa.buf_waddr_i = a;
    ifa.buf_wbe_i   = be;
    ifa.buf_wdata_i = d;
    tick();
    ifa.buf_wren_i  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40 && ifa.comp_ready_o !== 1'b1; i++) tick();
    check(tag, {31'd0, ifa.comp_ready_o}, 32'd1);
  endtask

  // Start, wait for ready, pop all 16 words back-to-back into wa/wb
  task automatic run_block(input string tag);
    ifa.comp_start_i = 1'b1;
    tick();
    ifa.comp_start_i = 1'b0;
    wait_ready(tag);
    for (int k = 0; k < 16; k++) begin
      wa[k] = ifa.comp_rdata_o;
      wb[k] = ifb.comp_rdata_o;
      ifa.comp_rden_i = 1'b1;
      tick();
    end
    ifa.comp_rden_i = 1'b0;
  endtask

  initial begin
    ifa.buf_wren_i   = 1'b0;
    ifa.buf_waddr_i  = '0;
    ifa.buf_wbe_i    = '0;
    ifa.buf_wdata_i  = '0;
    ifa.comp_start_i = 1'b0;
    ifa.comp_rden_i  = 1'b0;

    repeat (3) tick();
    check("rst_ready", {31'd0, ifa.comp_ready_o}, 32'd0);
    check("rst_rdata", ifa.comp_rdata_o, 32'd0);
    check("rst_ovf",   {31'd0, ifa.comp_ovf_o}, 32'd0);
    rst = 1'b0;
    tick();

    // All ones: 1.0 everywhere
    for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF, 64'h3F800000_3F800000);
    run_block("ones_ready");
    for (int k = 0; k < 16; k++) check($sformatf("ones_w%0d", k), wa[k], 32'h3F803F80);
    check("ones_ovf", {31'd0, ifa.comp_ovf_o}, 32'd0);
    check("ones_ready_fall", {31'd0, ifa.comp_ready_o}, 32'd0);

    // RNE ties and carry into exponent
    wr(4'd0, 8'hFF, 64'h3F808000_3F818000);
    wr(4'd1, 8'hFF, 64'h3F808001_BF7FFFFF);
    run_block("rne_ready");
    check("rne_w0", wa[0], 32'h3F823F80);
    check("rne_w1", wa[1], 32'hBF803F81);
    check("trn_w0", wb[0], 32'h3F813F80);
    check("trn_w1", wb[1], 32'hBF7F3F80);
    check("rne_ovf", {31'd0, ifa.comp_ovf_o}, 32'd0);

    // NaN quieting and overflow to Inf
    wr(4'd0, 8'hFF, 64'h7F800001_7F7FFFFF);
    run_block("ovf_ready");
    check("ovf_rne_w0", wa[0], 32'h7F807FC0);
    check("ovf_rne_flag", {31'd0, ifa.comp_ovf_o}, 32'd1);
    check("ovf_trn_w0", wb[0], 32'h7F7F7FC0);
    check("ovf_trn_flag", {31'd0, ifb.comp_ovf_o}, 32'd0);

    // Pops in idle are ignored
    ifa.comp_rden_i = 1'b1;
    repeat (3) tick();
    ifa.comp_rden_i = 1'b0;
    check("idle_rdata", ifa.comp_rdata_o, 32'd0);

    // Latency / order with a stray start mid-conversion
    for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF, {16'(a), 16'd0, 16'(a + 16), 16'd0});
    ifa.comp_start_i = 1'b1;
    tick();                       // after edge E
    ifa.comp_start_i = 1'b0;
    repeat (4) tick();
    ifa.comp_start_i = 1'b1;
    tick();                       // after E+5, stray start sampled in CONV
    ifa.comp_start_i = 1'b0;
    repeat (10) tick();           // after E+15
    check("lat_not_ready_e15", {31'd0, ifa.comp_ready_o}, 32'd0);
    tick();                       // after E+16
    check("lat_ready_e16", {31'd0, ifa.comp_ready_o}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        ifa.comp_rden_i = 1'b0;
        tick();
      end
      check($sformatf("ord_w%0d", k), ifa.comp_rdata_o, {16'(k + 16), 16'(k)});
      ifa.comp_rden_i  = 1'b1;
      ifa.comp_start_i = (k == 15);
      tick();
    end
    ifa.comp_rden_i  = 1'b0;
    ifa.comp_start_i = 1'b0;
    check("ord_ready_fall", {31'd0, ifa.comp_ready_o}, 32'd0);
    repeat (20) tick();
    check("final_pop_start_ignored", {31'd0, ifa.comp_ready_o}, 32'd0);
    check("idle_rdata_zero", ifa.comp_rdata_o, 32'd0);

    // Partial byte-enabled writes
    wr(4'd3, 8'hF0, 64'h40000000_DEADBEEF);
    wr(4'd3, 8'h0F, 64'hCAFEF00D_C0000000);
    run_block("part_ready");
    check("part_w3", wa[3], 32'hC0004000);

    // Reset during conversion, then a block from the cleared buffer
    ifa.comp_start_i = 1'b1;
    tick();
    ifa.comp_start_i = 1'b0;
    repeat (7) tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, ifa.comp_ready_o}, 32'd0);
    check("mid_rst_rdata", ifa.comp_rdata_o, 32'd0);
    check("mid_rst_ovf",   {31'd0, ifa.comp_ovf_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_block("zero_ready");
    for (int k = 0; k < 16; k++) check($sformatf("zero_w%0d", k), wa[k], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
